// File: rtl/uart_debug_unit.sv
// Debug unit for a pipelined CPU: loads instructions over an embedded 8N1 UART,
// runs or single-steps the pipeline, then dumps PC, cycle count, registers and dirty memory.
module uart_debug_unit #(
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned ADDRWIDTH = 7,
    parameter int unsigned NB_STATE  = 15
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_halt,
    input  logic                 i_rx_data,
    input  logic [ADDRWIDTH-1:0] i_send_program_counter,
    input  logic [ADDRWIDTH-1:0] i_cant_cycles,
    input  logic [NB_DATA-1:0]   i_reg_debug_unit,
    input  logic                 i_bit_sucio,
    input  logic [NB_DATA-1:0]   i_mem_debug_unit,
    output logic [4:0]           o_addr_reg_debug_unit,
    output logic [ADDRWIDTH-1:0] o_addr_mem_debug_unit,
    output logic                 o_ctrl_addr_debug_mem,
    output logic                 o_ctrl_wr_debug_mem,
    output logic                 o_ctrl_read_debug_reg,
    output logic                 o_tx_data,
    output logic                 o_en_write,
    output logic                 o_en_read,
    output logic                 o_enable_pipe,
    output logic                 o_enable_mem,
    output logic                 o_debug_unit_reg,
    output logic [NB_DATA-1:0]   o_inst_load,
    output logic [ADDRWIDTH-1:0] o_address,
    output logic [NB_STATE-1:0]  o_state
);
    localparam int unsigned DivRaw = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int unsigned Div    = (DivRaw == 0) ? 1 : DivRaw;
    localparam int unsigned DivW   = $clog2(Div + 1);

    typedef enum logic [3:0] {
        StIdle, StRxCount, StRxInst, StWriteInst, StRxMode, StRun, StStepWait, StStepExec,
        StSendPc, StSendCyc, StRegAddr, StSendReg, StMemAddr, StSendMem, StDone
    } state_e;
    typedef enum logic [1:0] {UaIdle, UaStart, UaData, UaStop} uart_e;

    logic [DivW-1:0]      tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic [1:0]           rx_sync_q, rx_sync_d;
    uart_e                rx_st_q, rx_st_d, tx_st_q, tx_st_d;
    logic [3:0]           rx_s_q, rx_s_d, tx_s_q, tx_s_d;
    logic [2:0]           rx_n_q, rx_n_d, tx_n_q, tx_n_d;
    logic [7:0]           rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic                 rx, rx_done, tx_done, tx_start;
    logic [7:0]           tx_byte;
    state_e               state_q, state_d;
    logic [7:0]           count_q, count_d, wr_cnt_q, wr_cnt_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [31:0]          word_q, word_d, send_word;
    logic [2:0]           byte_q, byte_d, send_last;
    logic [6:0]           idx_q, idx_d;
    logic                 wait_q, wait_d, phase_q, phase_d, final_q, final_d;
    logic                 step_q, step_d, halted_q, halted_d, sending, last_sent;
    logic [1:0]           sel;

    assign tick = (tick_cnt_q == DivW'(Div - 1));
    assign rx   = rx_sync_q[1];

    // Receiver and transmitter, both paced by the shared 16x oversampling tick.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + DivW'(1);
        rx_sync_d  = {rx_sync_q[0], i_rx_data};
        rx_st_d = rx_st_q; rx_s_d = rx_s_q; rx_n_d = rx_n_q; rx_sh_d = rx_sh_q; rx_done = 1'b0;
        tx_st_d = tx_st_q; tx_s_d = tx_s_q; tx_n_d = tx_n_q; tx_sh_d = tx_sh_q; tx_done = 1'b0;
        if (tick) begin
            rx_s_d = rx_s_q + 4'd1;
            case (rx_st_q)
                UaIdle: begin
                    rx_s_d = '0;
                    if (!rx) rx_st_d = UaStart;
                end
                UaStart: if (rx_s_q == 4'd7) begin
                    rx_s_d  = '0;
                    rx_n_d  = '0;
                    rx_st_d = rx ? UaIdle : UaData;
                end
                UaData: if (rx_s_q == 4'd15) begin
                    rx_sh_d = {rx, rx_sh_q[7:1]};
                    rx_n_d  = rx_n_q + 3'd1;
                    if (rx_n_q == 3'd7) rx_st_d = UaStop;
                end
                default: if (rx_s_q == 4'd15) begin
                    rx_st_d = UaIdle;
                    rx_done = rx;
                end
            endcase
            if (tx_st_q != UaIdle) begin
                tx_s_d = tx_s_q + 4'd1;
                if (tx_s_q == 4'd15) begin
                    case (tx_st_q)
                        UaStart: begin
                            tx_st_d = UaData;
                            tx_n_d  = '0;
                        end
                        UaData: begin
                            tx_sh_d = {1'b0, tx_sh_q[7:1]};
                            tx_n_d  = tx_n_q + 3'd1;
                            if (tx_n_q == 3'd7) tx_st_d = UaStop;
                        end
                        default: begin
                            tx_st_d = UaIdle;
                            tx_done = 1'b1;
                        end
                    endcase
                end
            end
        end
        if (tx_st_q == UaIdle && tx_start) begin
            tx_st_d = UaStart;
            tx_s_d  = '0;
            tx_sh_d = tx_byte;
        end
    end

    assign o_tx_data = (tx_st_q == UaStart) ? 1'b0 : (tx_st_q == UaData) ? tx_sh_q[0] : 1'b1;

    always_comb begin
        state_d = state_q; count_d = count_q; wr_cnt_d = wr_cnt_q; addr_d = addr_q;
        word_d = word_q; byte_d = byte_q; idx_d = idx_q; wait_d = wait_q; phase_d = phase_q;
        final_d = final_q; step_d = step_q; halted_d = halted_q;
        o_en_write = 1'b0; o_en_read = 1'b0; o_enable_pipe = 1'b0; o_enable_mem = 1'b0;
        o_debug_unit_reg = 1'b0; o_ctrl_read_debug_reg = 1'b0;
        o_ctrl_addr_debug_mem = 1'b0; o_ctrl_wr_debug_mem = 1'b0;
        tx_start = 1'b0;

        case (state_q)
            StSendPc:  send_word = 32'(i_send_program_counter);
            StSendCyc: send_word = 32'(i_cant_cycles);
            StSendReg: send_word = 32'(i_reg_debug_unit);
            default:   send_word = 32'(i_mem_debug_unit);
        endcase
        // Memory frames carry an address byte ahead of the data word, so data shifts by one.
        if (state_q == StSendMem) begin
            sel       = 2'(3'd4 - byte_q);
            send_last = final_q ? 3'd0 : 3'd4;
            tx_byte   = final_q ? 8'hFF : (byte_q == 3'd0) ? {1'b0, idx_q}
                                        : send_word[{sel, 3'b000} +: 8];
        end else begin
            sel       = 2'd3 - byte_q[1:0];
            send_last = 3'd3;
            tx_byte   = send_word[{sel, 3'b000} +: 8];
        end
        sending   = (state_q == StSendPc) || (state_q == StSendCyc) ||
                    (state_q == StSendReg) || (state_q == StSendMem);
        last_sent = sending && wait_q && tx_done && (byte_q == send_last);
        if (sending) begin
            if (!wait_q) begin
                tx_start = 1'b1;
                wait_d   = 1'b1;
            end else if (tx_done) begin
                wait_d = 1'b0;
                byte_d = last_sent ? 3'd0 : byte_q + 3'd1;
            end
        end

        case (state_q)
            StIdle: state_d = StRxCount;
            StRxCount: begin
                o_debug_unit_reg = 1'b1;
                if (rx_done) begin
                    count_d  = rx_sh_q;
                    addr_d   = '0;
                    wr_cnt_d = '0;
                    byte_d   = '0;
                    state_d  = (rx_sh_q == 8'd0) ? StRxMode : StRxInst;
                end
            end
            StRxInst: begin
                o_debug_unit_reg = 1'b1;
                if (rx_done) begin
                    word_d = {word_q[23:0], rx_sh_q};
                    byte_d = (byte_q == 3'd3) ? 3'd0 : byte_q + 3'd1;
                    if (byte_q == 3'd3) state_d = StWriteInst;
                end
            end
            StWriteInst: begin
                o_debug_unit_reg = 1'b1;
                o_en_write       = 1'b1;
                addr_d           = addr_q + ADDRWIDTH'(1);
                wr_cnt_d         = wr_cnt_q + 8'd1;
                state_d          = (wr_cnt_q + 8'd1 == count_q) ? StRxMode : StRxInst;
            end
            StRxMode: if (rx_done && (rx_sh_q == 8'h10 || rx_sh_q == 8'h20)) begin
                step_d   = (rx_sh_q == 8'h20);
                halted_d = 1'b0;
                state_d  = (rx_sh_q == 8'h20) ? StStepWait : StRun;
            end
            StRun, StStepExec: begin
                o_enable_pipe = 1'b1;
                o_en_read     = 1'b1;
                o_enable_mem  = 1'b1;
                if (i_halt) halted_d = 1'b1;
                if (i_halt || state_q == StStepExec) begin
                    state_d = StSendPc;
                    byte_d  = '0;
                    wait_d  = 1'b0;
                end
            end
            StStepWait: if (rx_done) begin
                if (rx_sh_q == 8'h30) state_d = StStepExec;
                else if (rx_sh_q == 8'h40) state_d = StIdle;
            end
            StSendPc: if (last_sent) state_d = StSendCyc;
            StSendCyc: if (last_sent) begin
                idx_d   = '0;
                state_d = StRegAddr;
            end
            StRegAddr: begin
                o_ctrl_read_debug_reg = 1'b1;
                state_d               = StSendReg;
            end
            StSendReg: begin
                o_ctrl_read_debug_reg = 1'b1;
                if (last_sent) begin
                    idx_d   = (idx_q == 7'd31) ? 7'd0 : idx_q + 7'd1;
                    state_d = (idx_q == 7'd31) ? StMemAddr : StRegAddr;
                end
            end
            StMemAddr, StSendMem: begin
                o_ctrl_addr_debug_mem = 1'b1;
                o_ctrl_wr_debug_mem   = 1'b1;
                o_enable_mem          = 1'b1;
                // phase_q marks the second MEM_ADDR cycle, when read data is valid.
                if (state_q == StMemAddr) begin
                    phase_d = !phase_q;
                    if (phase_q) begin
                        if (i_bit_sucio || idx_q == 7'd127) state_d = StSendMem;
                        if (!i_bit_sucio && idx_q == 7'd127) final_d = 1'b1;
                        if (!i_bit_sucio && idx_q != 7'd127) idx_d = idx_q + 7'd1;
                    end
                end else if (last_sent) begin
                    if (final_q) begin
                        final_d = 1'b0;
                        state_d = StDone;
                    end else if (idx_q == 7'd127) begin
                        final_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = StMemAddr;
                    end
                end
            end
            default: state_d = (step_q && !halted_q) ? StStepWait : StIdle;
        endcase
    end

    assign o_addr_reg_debug_unit = idx_q[4:0];
    assign o_addr_mem_debug_unit = ADDRWIDTH'(idx_q);
    assign o_inst_load           = NB_DATA'(word_q);
    assign o_address             = addr_q;
    assign o_state               = NB_STATE'(1) << state_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt_q <= '0; rx_sync_q <= '0;
            rx_st_q <= UaIdle; rx_s_q <= '0; rx_n_q <= '0; rx_sh_q <= '0;
            tx_st_q <= UaIdle; tx_s_q <= '0; tx_n_q <= '0; tx_sh_q <= '0;
            state_q <= StIdle; count_q <= '0; wr_cnt_q <= '0; addr_q <= '0; word_q <= '0;
            byte_q <= '0; idx_q <= '0; wait_q <= 1'b0; phase_q <= 1'b0; final_q <= 1'b0;
            step_q <= 1'b0; halted_q <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d; rx_sync_q <= rx_sync_d;
            rx_st_q <= rx_st_d; rx_s_q <= rx_s_d; rx_n_q <= rx_n_d; rx_sh_q <= rx_sh_d;
            tx_st_q <= tx_st_d; tx_s_q <= tx_s_d; tx_n_q <= tx_n_d; tx_sh_q <= tx_sh_d;
            state_q <= state_d; count_q <= count_d; wr_cnt_q <= wr_cnt_d; addr_q <= addr_d;
            word_q <= word_d; byte_q <= byte_d; idx_q <= idx_d; wait_q <= wait_d;
            phase_q <= phase_d; final_q <= final_d; step_q <= step_d; halted_q <= halted_d;
        end
    end
endmodule

// File: tb/tb_uart_debug_unit.sv
// Directed bench for uart_debug_unit: host byte table for upload/mode, then run, step and reset
// sequences with a serial decoder on the TX line.
`timescale 1ns/1ps
module tb_uart_debug_unit;
    localparam int unsigned Baud    = 115200;
    localparam int unsigned ClkFreq = 1843200;  // divisor 1: 16 clocks per serial bit
    localparam int          BitClk  = 16;
    localparam int          DumpLen = 142;

    localparam logic [14:0] SIdle = 15'h0001, SRxCount = 15'h0002, SRxInst = 15'h0004;
    localparam logic [14:0] SRxMode = 15'h0010, SRun = 15'h0020, SStepWait = 15'h0040;
    localparam logic [14:0] SSendPc = 15'h0100;

    logic        clk = 1'b0, rst = 1'b1, halt = 1'b0, rx = 1'b1;
    logic [6:0]  pc = 7'd3, cyc = 7'd4;
    logic [31:0] reg_data, mem_data, inst_load;
    logic        sucio, ctrl_addr, ctrl_wr, ctrl_read, tx, en_write, en_read, en_pipe, en_mem, dbg;
    logic [4:0]  addr_reg;
    logic [6:0]  addr_mem, address;
    logic [14:0] state;

    int n_cmp = 0, n_err = 0;
    int pipe_cycles = 0, ctrl_viol = 0, onehot_viol = 0;
    logic [7:0]  tx_log[$];
    logic [6:0]  wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [7:0]  exp_dump[$];

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [14:0] exp_state;
        logic        exp_dbg;
        string       name;
    } vec_t;
    vec_t vecs[12];

    uart_debug_unit #(.BAUD_RATE(Baud), .CLK_FREQ(ClkFreq)) dut (
        .i_clock(clk), .i_reset(rst), .i_halt(halt), .i_rx_data(rx),
        .i_send_program_counter(pc), .i_cant_cycles(cyc), .i_reg_debug_unit(reg_data),
        .i_bit_sucio(sucio), .i_mem_debug_unit(mem_data),
        .o_addr_reg_debug_unit(addr_reg), .o_addr_mem_debug_unit(addr_mem),
        .o_ctrl_addr_debug_mem(ctrl_addr), .o_ctrl_wr_debug_mem(ctrl_wr),
        .o_ctrl_read_debug_reg(ctrl_read), .o_tx_data(tx), .o_en_write(en_write),
        .o_en_read(en_read), .o_enable_pipe(en_pipe), .o_enable_mem(en_mem),
        .o_debug_unit_reg(dbg), .o_inst_load(inst_load), .o_address(address), .o_state(state)
    );

    always #5 clk = ~clk;

    // Register file returns its own address; only word 5 of data memory is dirty.
    assign reg_data = {27'd0, addr_reg};
    assign sucio    = (addr_mem == 7'd5);
    assign mem_data = (addr_mem == 7'd5) ? 32'hDEADBEEF : 32'h0;

    always @(negedge clk) begin
        if (!rst) begin
            if (en_write) begin
                wr_addr_log.push_back(address);
                wr_data_log.push_back(inst_load);
            end
            if (en_pipe) pipe_cycles++;
            if ((state[10] | state[11]) != ctrl_read) ctrl_viol++;
            if ((state[12] | state[13]) != ctrl_addr) ctrl_viol++;
            if ((state[12] | state[13]) && !(ctrl_wr && en_mem)) ctrl_viol++;
        end
        if ($countones(state) != 1) onehot_viol++;
    end

    initial begin : tx_decoder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (BitClk / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BitClk) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (BitClk) @(negedge clk);
                    tx_log.push_back(b);
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BitClk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BitClk) @(negedge clk);
        end
        rx = stop;
        repeat (BitClk) @(negedge clk);
        rx = 1'b1;
        repeat (stop ? 4 : 200) @(negedge clk);
    endtask

    task automatic check_dump(input int base, input string tag);
        for (int c = 0; c < 40000 && tx_log.size() < base + DumpLen; c++) @(negedge clk);
        repeat (40) @(negedge clk);
        check({tag, " byte count"}, tx_log.size() - base, DumpLen);
        for (int i = 0; i < DumpLen && base + i < tx_log.size(); i++)
            check($sformatf("%s byte %0d", tag, i), {24'd0, tx_log[base + i]}, {24'd0, exp_dump[i]});
    endtask

    initial begin
        int base, pipe_base, wr_base;
        vecs[0]  = '{8'h02, 1'b1, SRxInst, 1'b1, "count 2"};
        vecs[1]  = '{8'h02, 1'b1, SRxInst, 1'b1, "w0 b0"};
        vecs[2]  = '{8'h03, 1'b1, SRxInst, 1'b1, "w0 b1"};
        vecs[3]  = '{8'h04, 1'b1, SRxInst, 1'b1, "w0 b2"};
        vecs[4]  = '{8'h05, 1'b1, SRxInst, 1'b1, "w0 b3"};
        vecs[5]  = '{8'h06, 1'b1, SRxInst, 1'b1, "w1 b0"};
        vecs[6]  = '{8'h07, 1'b1, SRxInst, 1'b1, "w1 b1"};
        vecs[7]  = '{8'h08, 1'b1, SRxInst, 1'b1, "w1 b2"};
        vecs[8]  = '{8'h09, 1'b1, SRxMode, 1'b0, "w1 b3"};
        vecs[9]  = '{8'h10, 1'b0, SRxMode, 1'b0, "run byte bad stop"};
        vecs[10] = '{8'h55, 1'b1, SRxMode, 1'b0, "unknown mode"};
        vecs[11] = '{8'h10, 1'b1, SRun,    1'b0, "run"};

        for (int i = 0; i < 4; i++) exp_dump.push_back((i == 3) ? 8'h03 : 8'h00);
        for (int i = 0; i < 4; i++) exp_dump.push_back((i == 3) ? 8'h04 : 8'h00);
        for (int k = 0; k < 32; k++)
            for (int i = 0; i < 4; i++) exp_dump.push_back((i == 3) ? 8'(k) : 8'h00);
        exp_dump.push_back(8'h05); exp_dump.push_back(8'hDE); exp_dump.push_back(8'hAD);
        exp_dump.push_back(8'hBE); exp_dump.push_back(8'hEF); exp_dump.push_back(8'hFF);

        repeat (5) @(negedge clk);
        check("reset state", state, SIdle);
        check("reset tx", tx, 1'b1);
        check("reset outputs", {en_write, en_pipe, en_read, en_mem, dbg, ctrl_read}, 6'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("after reset state", state, SRxCount);
        check("after reset dbg", dbg, 1'b1);

        for (int i = 0; i < 12; i++) begin
            send_byte(vecs[i].data, vecs[i].stop);
            check({vecs[i].name, " state"}, state, vecs[i].exp_state);
            check({vecs[i].name, " dbg_reg"}, dbg, vecs[i].exp_dbg);
        end
        check("write count", wr_addr_log.size(), 2);
        if (wr_addr_log.size() >= 2) begin
            check("write0 addr", wr_addr_log[0], 7'd0);
            check("write0 data", wr_data_log[0], 32'h02030405);
            check("write1 addr", wr_addr_log[1], 7'd1);
            check("write1 data", wr_data_log[1], 32'h06070809);
        end

        check("run enables", {en_pipe, en_read, en_mem}, 3'b111);
        base = tx_log.size();
        @(negedge clk) halt = 1'b1;
        @(negedge clk) halt = 1'b0;
        check("halt drops pipe", en_pipe, 1'b0);
        check("halt state", state, SSendPc);
        check_dump(base, "run dump");
        check("after run dump state", state, SRxCount);

        send_byte(8'h00, 1'b1);
        check("count 0 state", state, SRxMode);
        send_byte(8'h20, 1'b1);
        check("step mode state", state, SStepWait);
        pipe_base = pipe_cycles;
        base = tx_log.size();
        send_byte(8'h30, 1'b1);
        check_dump(base, "step dump");
        check("step enable cycles", pipe_cycles - pipe_base, 1);
        check("after step dump state", state, SStepWait);
        send_byte(8'h40, 1'b1);
        check("step exit state", state, SRxCount);

        wr_base = wr_addr_log.size();
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid reset state", state, SIdle);
        check("mid reset tx", tx, 1'b1);
        check("mid reset addr/data", {address, inst_load}, 39'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no write on abort", wr_addr_log.size() - wr_base, 0);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        check("reload state", state, SRxMode);
        check("reload write count", wr_addr_log.size() - wr_base, 1);
        if (wr_addr_log.size() > wr_base) begin
            check("reload addr", wr_addr_log[wr_base], 7'd0);
            check("reload data", wr_data_log[wr_base], 32'hAABBCCDD);
        end

        check("dump control outputs", ctrl_viol, 0);
        check("one-hot state", onehot_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
